// File: rtl/if_prefetch_stage_if.sv
// IF stage bus bundle: branch redirect input, split addr_ok/data_ok instruction bus,
// and the IF->ID valid/allow_in handshake with {pc, inst, adef} payload.
interface if_prefetch_stage_if;
  logic        br_taken;
  logic [31:0] br_target;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        ds_allow_in;
  logic        fs_to_ds_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic        fs_adef;

  // The fetch stage itself.
  modport master (
    input  br_taken, br_target, inst_addr_ok, inst_data_ok, inst_rdata, ds_allow_in,
    output inst_req, inst_addr, fs_to_ds_valid, fs_pc, fs_inst, fs_adef
  );

  // Everything around it: redirect logic, instruction bus slave, ID stage.
  modport slave (
    output br_taken, br_target, inst_addr_ok, inst_data_ok, inst_rdata, ds_allow_in,
    input  inst_req, inst_addr, fs_to_ds_valid, fs_pc, fs_inst, fs_adef
  );
endinterface

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: credit-limited pipelined requests, in-order response matching,
// prefetch FIFO towards ID, branch flush with in-flight discard, misaligned-PC exception entry.
module if_prefetch_stage #(
  parameter logic [31:0] RESET_PC        = 32'h1c000000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic                clk,
  input  logic                resetn,
  if_prefetch_stage_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [31:0]   pc_req_q, pc_req_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [CW-1:0] discard_q, discard_d;
  logic          adef_stall_q, adef_stall_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0] fifo_rd_q, fifo_rd_d;
  logic [PW-1:0] fifo_wr_q, fifo_wr_d;
  logic [QW-1:0] pend_rd_q, pend_rd_d;
  logic [QW-1:0] pend_wr_q, pend_wr_d;

  logic [31:0]   fifo_pc_q   [FIFO_DEPTH];
  logic [31:0]   fifo_inst_q [FIFO_DEPTH];
  logic          fifo_adef_q [FIFO_DEPTH];
  logic [31:0]   pend_pc_q   [MAX_OUTSTANDING];

  logic          fifo_empty, fifo_full, aligned, credit_ok;
  logic [CW:0]   credit_used;
  logic          acc, rsp, rsp_drop, rsp_keep, adef_push, fifo_push, fifo_pop, head_vis;
  logic [31:0]   push_pc, push_inst;
  logic          push_adef;

  function automatic logic [QW-1:0] pend_next(input logic [QW-1:0] p);
    return (p == QW'(MAX_OUTSTANDING - 1)) ? '0 : p + QW'(1);
  endfunction

  // Credits count discarded-but-in-flight requests as free: their data never lands in the FIFO.
  always_comb begin
    fifo_empty  = (fifo_cnt_q == '0);
    fifo_full   = (fifo_cnt_q == CW'(FIFO_DEPTH));
    aligned     = (pc_req_q[1:0] == 2'b00);
    credit_used = {1'b0, fifo_cnt_q} + {1'b0, out_cnt_q} - {1'b0, discard_q};
    credit_ok   = (out_cnt_q < CW'(MAX_OUTSTANDING)) && (credit_used < (CW+1)'(FIFO_DEPTH));
  end

  assign bus.inst_req       = resetn & ~bus.br_taken & ~adef_stall_q & aligned & credit_ok;
  assign bus.inst_addr      = pc_req_q;
  assign head_vis           = resetn & ~fifo_empty;
  assign bus.fs_to_ds_valid = head_vis & ~bus.br_taken;
  assign bus.fs_pc          = head_vis ? fifo_pc_q[fifo_rd_q]   : 32'h0;
  assign bus.fs_inst        = head_vis ? fifo_inst_q[fifo_rd_q] : 32'h0;
  assign bus.fs_adef        = head_vis & fifo_adef_q[fifo_rd_q];

  always_comb begin
    acc       = bus.inst_req & bus.inst_addr_ok;
    rsp       = bus.inst_data_ok;
    rsp_drop  = rsp & (discard_q != '0);
    rsp_keep  = rsp & (discard_q == '0) & ~bus.br_taken;
    adef_push = ~bus.br_taken & ~adef_stall_q & ~aligned & (out_cnt_q == '0)
              & (discard_q == '0) & ~fifo_full;
    fifo_push = rsp_keep | adef_push;
    fifo_pop  = bus.fs_to_ds_valid & bus.ds_allow_in;
    push_pc   = adef_push ? pc_req_q : pend_pc_q[pend_rd_q];
    push_inst = adef_push ? 32'h0 : bus.inst_rdata;
    push_adef = adef_push;
  end

  always_comb begin
    pc_req_d     = pc_req_q;
    adef_stall_d = adef_stall_q;
    out_cnt_d    = out_cnt_q + CW'(acc) - CW'(rsp);
    pend_wr_d    = acc ? pend_next(pend_wr_q) : pend_wr_q;
    pend_rd_d    = rsp ? pend_next(pend_rd_q) : pend_rd_q;
    discard_d    = discard_q - CW'(rsp_drop);
    fifo_cnt_d   = fifo_cnt_q + CW'(fifo_push) - CW'(fifo_pop);
    fifo_rd_d    = fifo_rd_q + PW'(fifo_pop);
    fifo_wr_d    = fifo_wr_q + PW'(fifo_push);
    if (bus.br_taken) begin
      // Everything still in flight after this edge belongs to the old path.
      pc_req_d     = bus.br_target;
      adef_stall_d = 1'b0;
      discard_d    = out_cnt_d;
      fifo_cnt_d   = '0;
      fifo_rd_d    = '0;
      fifo_wr_d    = '0;
    end else begin
      if (acc)       pc_req_d     = pc_req_q + 32'd4;
      if (adef_push) adef_stall_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_req_q     <= RESET_PC;
      out_cnt_q    <= '0;
      discard_q    <= '0;
      adef_stall_q <= 1'b0;
      fifo_cnt_q   <= '0;
      fifo_rd_q    <= '0;
      fifo_wr_q    <= '0;
      pend_rd_q    <= '0;
      pend_wr_q    <= '0;
    end else begin
      pc_req_q     <= pc_req_d;
      out_cnt_q    <= out_cnt_d;
      discard_q    <= discard_d;
      adef_stall_q <= adef_stall_d;
      fifo_cnt_q   <= fifo_cnt_d;
      fifo_rd_q    <= fifo_rd_d;
      fifo_wr_q    <= fifo_wr_d;
      pend_rd_q    <= pend_rd_d;
      pend_wr_q    <= pend_wr_d;
    end
  end

  // Payload storage carries no reset; validity comes from the counters and pointers.
  always_ff @(posedge clk) begin
    if (acc) pend_pc_q[pend_wr_q] <= pc_req_q;
    if (fifo_push) begin
      fifo_pc_q[fifo_wr_q]   <= push_pc;
      fifo_inst_q[fifo_wr_q] <= push_inst;
      fifo_adef_q[fifo_wr_q] <= push_adef;
    end
  end

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!resetn)
    bus.inst_data_ok |-> (out_cnt_q != '0));
  a_no_push_full: assert property (@(posedge clk) disable iff (!resetn)
    fifo_push |-> !fifo_full);
endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: bus slave model plus a sequential-PC reference stream for ID.
module tb_if_prefetch_stage;
  localparam logic [31:0] RESET_PC = 32'h1c000000;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  if_prefetch_stage_if bus ();

  if_prefetch_stage #(
    .RESET_PC(RESET_PC), .FIFO_DEPTH(4), .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5a5a_0f0f;
  endfunction

  // Environment knobs
  int aok_pct, dok_pct, ds_pct, lat_min, lat_max;
  // Bus slave: accepted addresses in order with earliest response cycle
  logic [31:0] sq_addr[$];
  int          sq_rdy[$];
  // Reference model: next request address and next PC ID should see
  logic [31:0] exp_req_pc, exp_pc;
  bit          exp_done;
  int          cyc;
  bit          prev_hold, prev_br, prev_rst;
  logic [31:0] prev_addr;
  int          pop_cnt, acc_cnt, adef_cnt, first_acc, first_vld;
  logic        s_req, s_vld;

  task automatic cycle(input bit rst_n, input bit br, input logic [31:0] tgt);
    bit dok, acc, pop;
    logic [31:0] acc_addr;
    @(negedge clk);
    resetn           = rst_n;
    bus.br_taken     = br;
    bus.br_target    = tgt;
    bus.inst_addr_ok = (int'($urandom_range(99)) < aok_pct);
    bus.ds_allow_in  = (int'($urandom_range(99)) < ds_pct);
    dok = rst_n && (sq_addr.size() > 0) && (sq_rdy[0] <= cyc) && (int'($urandom_range(99)) < dok_pct);
    bus.inst_data_ok = dok;
    bus.inst_rdata   = dok ? mem(sq_addr[0]) : $urandom;
    #1;
    s_req    = bus.inst_req;
    s_vld    = bus.fs_to_ds_valid;
    acc      = rst_n && bus.inst_req && bus.inst_addr_ok;
    acc_addr = bus.inst_addr;
    pop      = rst_n && bus.fs_to_ds_valid && bus.ds_allow_in && !br;
    if (!rst_n) begin
      check_val("rst_req", 32'(bus.inst_req), 32'd0);
      check_val("rst_vld", 32'(bus.fs_to_ds_valid), 32'd0);
    end else begin
      if (prev_rst) begin
        check_val("post_rst_vld", 32'(bus.fs_to_ds_valid), 32'd0);
        check_val("post_rst_pc", bus.fs_pc, 32'd0);
        check_val("post_rst_inst", bus.fs_inst, 32'd0);
        check_val("post_rst_adef", 32'(bus.fs_adef), 32'd0);
      end
      if (br) begin
        check_val("br_vld", 32'(bus.fs_to_ds_valid), 32'd0);
        check_val("br_req", 32'(bus.inst_req), 32'd0);
      end
      if (prev_br) check_val("post_br_vld", 32'(bus.fs_to_ds_valid), 32'd0);
      if (prev_hold && !br) begin
        check_val("req_hold", 32'(bus.inst_req), 32'd1);
        check_val("addr_hold", bus.inst_addr, prev_addr);
      end
      if (exp_req_pc[1:0] != 2'b00) check_val("misaligned_req", 32'(bus.inst_req), 32'd0);
      else if (bus.inst_req) check_val("req_addr", bus.inst_addr, exp_req_pc);
      if (pop) begin
        pop_cnt++;
        if (exp_done) begin
          check_val("pop_after_adef", 32'(exp_done), 32'd0);
        end else if (exp_pc[1:0] != 2'b00) begin
          check_val("adef_pc", bus.fs_pc, exp_pc);
          check_val("adef_inst", bus.fs_inst, 32'd0);
          check_val("adef_flag", 32'(bus.fs_adef), 32'd1);
          exp_done = 1'b1;
          adef_cnt++;
        end else begin
          check_val("pop_pc", bus.fs_pc, exp_pc);
          check_val("pop_inst", bus.fs_inst, mem(exp_pc));
          check_val("pop_adef", 32'(bus.fs_adef), 32'd0);
          exp_pc = exp_pc + 32'd4;
        end
      end
    end
    prev_hold = rst_n && bus.inst_req && !bus.inst_addr_ok;
    prev_addr = bus.inst_addr;
    prev_br   = rst_n && br;
    prev_rst  = !rst_n;
    if (acc) begin
      acc_cnt++;
      if (first_acc < 0) first_acc = cyc;
    end
    if (rst_n && bus.fs_to_ds_valid && first_vld < 0) first_vld = cyc;
    @(posedge clk);
    if (!rst_n) begin
      sq_addr.delete();
      sq_rdy.delete();
      exp_req_pc = RESET_PC;
      exp_pc     = RESET_PC;
      exp_done   = 1'b0;
    end else begin
      if (dok) begin
        void'(sq_addr.pop_front());
        void'(sq_rdy.pop_front());
      end
      if (acc) begin
        sq_addr.push_back(acc_addr);
        sq_rdy.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
      end
      if (br) begin
        exp_req_pc = tgt;
        exp_pc     = tgt;
        exp_done   = 1'b0;
      end else if (acc) begin
        exp_req_pc = exp_req_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 32'h0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    int p0, a0, base, budget;
    bit did_rst, br;
    logic [31:0] tgt;
    resetn = 1'b0;
    bus.br_taken = 1'b0; bus.br_target = '0; bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0; bus.inst_rdata = '0; bus.ds_allow_in = 1'b0;
    cyc = 0; pop_cnt = 0; acc_cnt = 0; adef_cnt = 0;
    prev_hold = 0; prev_br = 0; prev_rst = 0;
    exp_req_pc = RESET_PC; exp_pc = RESET_PC; exp_done = 0;
    aok_pct = 100; dok_pct = 100; ds_pct = 100; lat_min = 1; lat_max = 1;

    // Streaming from reset: one request per cycle, first valid two cycles after first accept
    do_reset(3);
    first_acc = -1; first_vld = -1; a0 = acc_cnt;
    run(12);
    check_val("stream_accepts", 32'(acc_cnt - a0), 32'd12);
    check_val("first_latency", 32'(first_vld - first_acc), 32'd2);

    // ID stalled: FIFO fills, requests stop, then drains 4 entries in order
    do_reset(2);
    ds_pct = 0;
    run(20);
    check_val("full_req", 32'(s_req), 32'd0);
    check_val("full_vld", 32'(s_vld), 32'd1);
    aok_pct = 0; ds_pct = 100; p0 = pop_cnt;
    run(8);
    check_val("drain_count", 32'(pop_cnt - p0), 32'd4);

    // Redirect with two requests in flight
    aok_pct = 100; lat_min = 4; lat_max = 4;
    run(6);
    cycle(1'b1, 1'b1, 32'h1c000100);
    p0 = pop_cnt;
    run(15);
    check_val("redirect_resume", 32'(pop_cnt > p0), 32'd1);

    // Redirect coincident with data_ok and a valid head
    lat_min = 1; lat_max = 1;
    run(6);
    cycle(1'b1, 1'b1, 32'h1c000300);
    run(10);

    // Misaligned target: one ADEF entry, then fetch stalls until the next redirect
    lat_min = 3; lat_max = 3;
    run(5);
    a0 = adef_cnt;
    cycle(1'b1, 1'b1, 32'h1c000102);
    run(15);
    check_val("adef_entries", 32'(adef_cnt - a0), 32'd1);
    check_val("adef_stall_req", 32'(s_req), 32'd0);
    cycle(1'b1, 1'b1, 32'h1c000200);
    p0 = pop_cnt;
    run(10);
    check_val("adef_resume", 32'(pop_cnt > p0), 32'd1);

    // Randomised traffic with occasional redirects and one mid-stream reset
    aok_pct = 50; dok_pct = 70; ds_pct = 70; lat_min = 1; lat_max = 4;
    base = pop_cnt; budget = 0; did_rst = 0;
    while ((pop_cnt - base) < 1000 && budget < 30000) begin
      if (!did_rst && (pop_cnt - base) >= 500) begin
        do_reset(2);
        did_rst = 1;
      end
      br  = ($urandom_range(63) == 0) || ((exp_req_pc[1:0] != 2'b00) && ($urandom_range(7) == 0));
      tgt = 32'h1c000000 | (32'($urandom_range(4095)) << 2);
      if ($urandom_range(9) == 0) tgt[1:0] = 2'($urandom_range(3));
      cycle(1'b1, br, tgt);
      budget++;
    end
    check_val("random_stream_len", 32'((pop_cnt - base) >= 1000), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
